// File: rtl/regfile_wb_sequencer_if.sv
// Write-back request channel for the register-file sequencer.
// Carries the E and M destinations of one instruction with a valid/ready handshake.
interface regfile_wb_sequencer_if #(
  parameter int DW = 64
);
  logic          wb_valid;
  logic          wb_ready;
  logic [3:0]    wb_dstE;
  logic [DW-1:0] wb_valE;
  logic [3:0]    wb_dstM;
  logic [DW-1:0] wb_valM;

  modport master (
    output wb_valid,
    output wb_dstE,
    output wb_valE,
    output wb_dstM,
    output wb_valM,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_dstE,
    input  wb_valE,
    input  wb_dstM,
    input  wb_valM,
    output wb_ready
  );
endinterface

// File: rtl/regfile_wb_sequencer.sv
// Y86-64 write-back sequencer: serialises E then M writes onto one RF port.
// Pending-write scoreboard is built only when REGFILE_SCOREBOARD_EN is defined.
module regfile_wb_sequencer #(
  parameter int NREG = 15,
  parameter int DW   = 64
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_sequencer_if.slave wb,
  output logic                rf_we,
  output logic [3:0]          rf_waddr,
  output logic [DW-1:0]       rf_wdata,
  input  logic [3:0]          rd_srcA,
  input  logic [3:0]          rd_srcB,
  output logic [NREG-1:0]     pend_mask,
  output logic                rd_hazard
);

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WE,
    S_WM
  } state_t;

  state_t        st_q, st_d;
  logic [3:0]    dstE_q, dstM_q;
  logic [DW-1:0] valE_q, valM_q;
  logic          fin;
  logic          accept;

  always_comb begin
    st_d = st_q;
    fin  = 1'b0;
    unique case (st_q)
      S_IDLE: fin = 1'b1;
      S_WE: begin
        if (dstM_q != RNONE) st_d = S_WM;
        else                 fin  = 1'b1;
      end
      S_WM:   fin = 1'b1;
      default: fin = 1'b1;
    endcase
    // Ready exactly in the last write cycle lets the next request follow with no bubble
    if (fin) begin
      if (accept) begin
        if (wb.wb_dstE != RNONE)      st_d = S_WE;
        else if (wb.wb_dstM != RNONE) st_d = S_WM;
        else                          st_d = S_IDLE;
      end else begin
        st_d = S_IDLE;
      end
    end
  end

  assign wb.wb_ready = fin;
  assign accept      = wb.wb_valid && fin;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_IDLE;
      dstE_q <= RNONE;
      dstM_q <= RNONE;
      valE_q <= '0;
      valM_q <= '0;
    end else begin
      st_q <= st_d;
      if (accept) begin
        dstE_q <= wb.wb_dstE;
        valE_q <= wb.wb_valE;
        dstM_q <= wb.wb_dstM;
        valM_q <= wb.wb_valM;
      end
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = RNONE;
    rf_wdata = '0;
    unique case (1'b1)
      (st_q == S_WE): begin
        rf_we    = 1'b1;
        rf_waddr = dstE_q;
        rf_wdata = valE_q;
      end
      (st_q == S_WM): begin
        rf_we    = 1'b1;
        rf_waddr = dstM_q;
        rf_wdata = valM_q;
      end
      default: ;
    endcase
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [15:0] pend_ext;

  // 0xF never matches since r stays below NREG
  always_comb begin
    pend_mask = '0;
    for (int r = 0; r < NREG; r++) begin
      pend_mask[r] = ((st_q == S_WE) && (dstE_q == 4'(r)))
                  || ((st_q != S_IDLE) && (dstM_q == 4'(r)));
    end
  end

  assign pend_ext  = {{(16-NREG){1'b0}}, pend_mask};
  assign rd_hazard = ((rd_srcA != RNONE) && pend_ext[rd_srcA])
                  || ((rd_srcB != RNONE) && pend_ext[rd_srcB]);
`else
  logic unused_rd;
  assign unused_rd = ^{rd_srcA, rd_srcB};
  assign pend_mask = '0;
  assign rd_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Bench for regfile_wb_sequencer: directed requests, queued expected writes.
// A negedge monitor pops the queue on every rf_we cycle.
module tb_regfile_wb_sequencer;

  localparam int NREG = 15;
  localparam int DW   = 64;

`ifdef REGFILE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  typedef struct {
    logic [3:0]    a;
    logic [DW-1:0] d;
  } wr_t;

  logic            clk;
  logic            rst;
  logic            rf_we;
  logic [3:0]      rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [3:0]      rd_srcA;
  logic [3:0]      rd_srcB;
  logic [NREG-1:0] pend_mask;
  logic            rd_hazard;

  regfile_wb_sequencer_if #(.DW(DW)) wb ();

  regfile_wb_sequencer #(.NREG(NREG), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb.slave),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rd_srcA   (rd_srcA),
    .rd_srcB   (rd_srcB),
    .pend_mask (pend_mask),
    .rd_hazard (rd_hazard)
  );

  int total = 0;
  int bad   = 0;
  wr_t exp_q[$];
  logic [DW-1:0] rf_model [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      wr_t e;
      rf_model[rf_waddr] = rf_wdata;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got %0h/%0h want none",
                 rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (rf_waddr !== e.a || rf_wdata !== e.d) begin
          bad++;
          $display("FAIL write: got %0h/%0h want %0h/%0h",
                   rf_waddr, rf_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] de, input logic [63:0] ve,
                     input logic [3:0] dm, input logic [63:0] vm);
    wb.wb_valid = 1'b1;
    wb.wb_dstE  = de;
    wb.wb_valE  = ve;
    wb.wb_dstM  = dm;
    wb.wb_valM  = vm;
    if (de != 4'hF) exp_q.push_back('{a: de, d: ve});
    if (dm != 4'hF) exp_q.push_back('{a: dm, d: vm});
  endtask

  task automatic idle_in;
    wb.wb_valid = 1'b0;
    wb.wb_dstE  = 4'hF;
    wb.wb_dstM  = 4'hF;
    wb.wb_valE  = '0;
    wb.wb_valM  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    rd_srcA = 4'hF;
    rd_srcB = 4'hF;
    idle_in();
    tick();
    tick();
    chk("rst_we", rf_we, 1'b0);
    chk("rst_waddr", rf_waddr, 4'hF);
    chk("rst_wdata", rf_wdata, 64'h0);
    chk("rst_ready", wb.wb_ready, 1'b1);
    chk("rst_pend", pend_mask, 15'h0);
    rst = 1'b0;
    tick();

    // OPq: single E write
    req(4'd3, 64'h10, 4'hF, 64'h0);
    chk("opq_ready_in", wb.wb_ready, 1'b1);
    tick();
    idle_in();
    chk("opq_we", rf_we, 1'b1);
    chk("opq_waddr", rf_waddr, 4'd3);
    chk("opq_ready", wb.wb_ready, 1'b1);
    tick();
    chk("opq_we_off", rf_we, 1'b0);

    // popq %rbx
    rd_srcA = 4'd3;
    req(4'd4, 64'h108, 4'd3, 64'hAB);
    tick();
    idle_in();
    chk("pop_c1_ready", wb.wb_ready, 1'b0);
    chk("pop_c1_pend", pend_mask, SB ? 15'h0018 : 15'h0);
    chk("pop_c1_haz", rd_hazard, SB);
    tick();
    chk("pop_c2_ready", wb.wb_ready, 1'b1);
    chk("pop_c2_pend", pend_mask, SB ? 15'h0008 : 15'h0);
    chk("pop_c2_haz", rd_hazard, SB);
    tick();
    chk("pop_c3_pend", pend_mask, 15'h0);
    chk("pop_c3_haz", rd_hazard, 1'b0);
    chk("pop_c3_we", rf_we, 1'b0);
    rd_srcA = 4'hF;

    // popq %rsp: same destination, M wins
    req(4'd4, 64'h108, 4'd4, 64'h55);
    tick();
    idle_in();
    chk("rsp_c1_addr", rf_waddr, 4'd4);
    tick();
    chk("rsp_c2_data", rf_wdata, 64'h55);
    tick();
    chk("rsp_final", rf_model[4], 64'h55);

    // back-to-back single-destination
    req(4'd1, 64'h11, 4'hF, 64'h0);
    tick();
    chk("b2b_we1", rf_we, 1'b1);
    chk("b2b_ready1", wb.wb_ready, 1'b1);
    req(4'hF, 64'h0, 4'd2, 64'h22);
    tick();
    chk("b2b_we2", rf_we, 1'b1);
    chk("b2b_addr2", rf_waddr, 4'd2);
    req(4'd5, 64'h55, 4'hF, 64'h0);
    tick();
    idle_in();
    chk("b2b_we3", rf_we, 1'b1);
    chk("b2b_addr3", rf_waddr, 4'd5);
    tick();
    chk("b2b_we_off", rf_we, 1'b0);

    // no destinations at all
    req(4'hF, 64'h1, 4'hF, 64'h2);
    tick();
    idle_in();
    chk("none_we", rf_we, 1'b0);
    chk("none_ready", wb.wb_ready, 1'b1);
    chk("none_pend", pend_mask, 15'h0);
    tick();

    // reset during the WE cycle discards the M write
    wb.wb_valid = 1'b1;
    wb.wb_dstE  = 4'd6;
    wb.wb_valE  = 64'h1;
    wb.wb_dstM  = 4'd7;
    wb.wb_valM  = 64'h2;
    exp_q.push_back('{a: 4'd6, d: 64'h1});
    tick();
    chk("rstm_we", rf_we, 1'b1);
    chk("rstm_addr", rf_waddr, 4'd6);
    rst         = 1'b1;
    wb.wb_dstE  = 4'd9;
    wb.wb_valE  = 64'h99;
    wb.wb_dstM  = 4'hF;
    tick();
    rst = 1'b0;
    idle_in();
    chk("rstm_we_off", rf_we, 1'b0);
    chk("rstm_pend", pend_mask, 15'h0);
    chk("rstm_ready", wb.wb_ready, 1'b1);
    chk("rstm_waddr", rf_waddr, 4'hF);
    tick();
    chk("rstm_no_m", rf_we, 1'b0);
    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
